// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and data/address types for the
// multiport register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Address width for a register count; never below 1 bit.
  function automatic int aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  localparam int AW_DEF = aw(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_multiport_if.sv
// Port bundle for the multiport register file: read lookups, write-back
// ports and the issue strobe.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = aw(NREGS);

  logic [NRD-1:0][AW-1:0]   rs;
  logic [NRD-1:0][XLEN-1:0] o_rs;
  logic [NRD-1:0]           o_busy;
  logic [NWR-1:0][AW-1:0]   rd;
  logic [NWR-1:0][XLEN-1:0] DataWr;
  logic [NWR-1:0]           RUWr;
  logic                     IssueValid;
  logic [AW-1:0]            IssueRd;

  modport master (
    output rs, rd, DataWr, RUWr, IssueValid, IssueRd,
    input  o_rs, o_busy
  );

  modport slave (
    input  rs, rd, DataWr, RUWr, IssueValid, IssueRd,
    output o_rs, o_busy
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets, write-back clears, set wins on conflict.
// Lookups are masked by same-cycle write-backs to the looked-up register.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NREGS = NREGS_DEF,
  parameter int  NRD   = 2,
  parameter int  NWR   = 2,
  localparam int AW    = aw(NREGS)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   IssueValid,
  input  logic [AW-1:0]          IssueRd,
  input  logic [NWR-1:0]         RUWr,
  input  logic [NWR-1:0][AW-1:0] rd,
  input  logic [NRD-1:0][AW-1:0] rs,
  output logic [NRD-1:0]         busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;
  logic [NRD-1:0]   wr_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (IssueValid) set_v[IssueRd] = 1'b1;
    for (int p = 0; p < NWR; p++) begin
      if (RUWr[p]) clr_v[rd[p]] = 1'b1;
    end
    set_v[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) busy_q <= '0;
    else        busy_q <= (busy_q & ~clr_v) | set_v;
  end

  always_comb begin
    wr_hit = '0;
    busy   = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int p = 0; p < NWR; p++) begin
        if (RUWr[p] && (rd[p] == rs[i])) wr_hit[i] = 1'b1;
      end
      busy[i] = busy_q[rs[i]] & ~wr_hit[i] & (rs[i] != '0);
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-read, multi-write register file with x0 hard-wired to zero,
// same-cycle write-to-read bypass and an attached busy scoreboard.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input logic                 Clk,
  input logic                 Rst_n,
  regfile_multiport_if.slave  bus
);

  localparam int AW = aw(NREGS);

  logic [XLEN-1:0]  regs  [NREGS];
  logic [XLEN-1:0]  wdata [NREGS];
  logic [NREGS-1:0] we;

  // NOTE: ports are scanned in ascending order, so the last match (highest port) wins.
  always_comb begin
    we = '0;
    for (int r = 0; r < NREGS; r++) wdata[r] = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.RUWr[p] && (bus.rd[p] == AW'(r))) begin
          we[r]    = 1'b1;
          wdata[r] = bus.DataWr[p];
        end
      end
    end
  end

  // NOTE: the array is a flop array, so it is reset like any other state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (we[r]) regs[r] <= wdata[r];
      end
    end
  end

  // regs[0] is never written, so it reads as zero without a special case.
  always_comb begin
    bus.o_rs = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.o_rs[i] = regs[bus.rs[i]];
      for (int p = 0; p < NWR; p++) begin
        if (bus.RUWr[p] && (bus.rd[p] == bus.rs[i]) && (bus.rs[i] != '0))
          bus.o_rs[i] = bus.DataWr[p];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .IssueValid (bus.IssueValid),
    .IssueRd    (bus.IssueRd),
    .RUWr       (bus.RUWr),
    .rd         (bus.rd),
    .rs         (bus.rs),
    .busy       (bus.o_busy)
  );

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter XLEN, default 32: register data width.
REQ-002 Parameter NREGS, default 32: register count, power of two, at least 2; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports.
REQ-004 Parameter NWR, default 2: number of write ports.
REQ-005 Clk  in  1: sole clock; all state updates on rising edge.
REQ-006 Rst_n  in  1: reset, asynchronous, active-low.
REQ-007 rs  in  NRD x AW: read addresses, one per read port.
REQ-008 o_rs  out  NRD x XLEN: read data, one per read port.
REQ-009 o_busy  out  NRD: scoreboard busy flag of each addressed register.
REQ-010 rd  in  NWR x AW: write addresses.
REQ-011 DataWr  in  NWR x XLEN: write data.
REQ-012 RUWr  in  NWR: per-port write enable.
REQ-013 IssueValid  in  1: an instruction issues and will write IssueRd.
REQ-014 IssueRd  in  AW: destination register of the issuing instruction.

Function
REQ-015 Register 0 SHALL always read 0, ignore writes and never be busy.
REQ-016 Each enabled write port with rd != 0 SHALL update its register on the rising Clk edge.
REQ-017 Multiple enabled ports with the same rd SHALL resolve so the highest-indexed port wins.
REQ-018 Reads SHALL be combinational with zero-cycle latency.
REQ-019 Write-to-read bypass: if an enabled port targets rs[i] != 0, o_rs[i] SHALL show that port's DataWr in the same cycle (highest port wins); otherwise it shows the stored value.
REQ-020 The scoreboard SHALL hold one busy bit per register.
REQ-021 On each edge, IssueValid with IssueRd != 0 SHALL set busy[IssueRd].
REQ-022 On each edge, an enabled write to rd != 0 SHALL clear busy[rd].
REQ-023 If a register is set by issue and cleared by write-back in the same cycle, set SHALL win and the bit stays 1.
REQ-024 o_busy[i] SHALL equal busy[rs[i]] AND NOT (an enabled write to rs[i] this cycle); it is 0 for rs[i] = 0.
REQ-025 Writes SHALL be accepted regardless of busy state; the scoreboard only reports.
REQ-026 Read ports SHALL be fully independent; identical addresses on all ports SHALL return identical data.

Reset
REQ-027 When Rst_n is low, all registers SHALL clear to 0 and all busy bits to 0 immediately, without waiting for Clk.
REQ-028 Writes and issues SHALL be ignored while Rst_n is low, including when reset asserts mid-cycle.
REQ-029 During reset, o_rs SHALL be 0 for all addresses except through the REQ-019 bypass path, and o_busy SHALL be 0.

Structure
REQ-030 Package regfile_pkg SHALL hold the XLEN and NREGS defaults, the AW function, and the typedefs reg_addr_t and reg_data_t.
REQ-031 The scoreboard SHALL be a separate sub-module, rf_scoreboard, with ports Clk, Rst_n, IssueValid, IssueRd, the write-back vectors and the read-address lookups.
REQ-032 The implementation SHALL need no vendor primitives; the storage array is a flop array.

Verification
REQ-033 Reset, then RUWr[0]=1, rd[0]=0, DataWr[0]=123; next cycle rs[0]=0 -> o_rs[0]=0, o_busy[0]=0.
REQ-034 Write x5=45 on port 0 and x10=100 on port 1 in the same cycle; next cycle rs = {5,10} -> o_rs = {45,100}.
REQ-035 Both ports write x7 with 11 (port 0) and 22 (port 1), rs[0]=7 in the same cycle -> o_rs[0]=22 combinationally, and after the edge x7=22.
REQ-036 Issue x3, then next cycle rs[1]=3 -> o_busy[1]=1; then write x3=9 -> o_busy[1]=0 that same cycle and o_rs[1]=9; next cycle busy stays 0.
REQ-037 Issue x4 and write x4 in the same cycle -> after the edge o_busy for x4 = 1, x4 holds the written data.
REQ-038 Load x5=45 and issue x6, then pull Rst_n low between edges -> o_rs for x5=0 and o_busy for x6=0 before the next Clk edge; after release, RUWr=0 keeps all registers at 0.
